// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register bridge.
// Holds the register byte offsets, the bit positions inside STATUS, CTRL
// and IRQ_EN, and the two-state bridge FSM encoding.
package uart_reg_pkg;

  // Register byte offsets. Address bits [1:0] are ignored by the bridge.
  localparam logic [4:0] TXDATA_OFS = 5'h00;
  localparam logic [4:0] RXDATA_OFS = 5'h04;
  localparam logic [4:0] STATUS_OFS = 5'h08;
  localparam logic [4:0] CTRL_OFS   = 5'h0C;
  localparam logic [4:0] IRQ_EN_OFS = 5'h10;

  // STATUS bit positions. Bits 4..6 are sticky and write-1-to-clear.
  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_FRAME_ERR = 4;
  localparam int STAT_RX_OVF    = 5;
  localparam int STAT_TX_DROP   = 6;
  localparam int STAT_W         = 7;

  // CTRL bit positions.
  localparam int CTRL_BAUD_LSB = 0;
  localparam int CTRL_BAUD_W   = 12;
  localparam int CTRL_PARITY   = 12;
  localparam int CTRL_TWO_STOP = 13;

  // IRQ_EN bit positions.
  localparam int IRQ_TX_READY = 0;
  localparam int IRQ_RX_AVAIL = 1;
  localparam int IRQ_ERR      = 2;
  localparam int IRQ_EN_W     = 3;

  // RXDATA valid flag position.
  localparam int RXDATA_VALID = 31;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bridge_state_t;

endpackage

// File: rtl/uart_reg_bridge.sv
// Memory-mapped register front end for the UART core: one outstanding
// single-beat transaction, request executed in the accept cycle, response
// held until consumed. Drives baud/parity/stop config, TX push, RX pop, irq.
// Ports: clk/reset_n; req_* request channel; rsp_* response channel;
// baud_div/parity_en/two_stop/tx_data/tx_wr_en/rx_rd_en to the UART;
// tx_*/rx_* flags, rx_data and error indicators from the UART; irq out.
module uart_reg_bridge
  import uart_reg_pkg::*;
#(
  parameter int          ADDR_W           = 5,
  parameter int          DATA_W           = 32,
  parameter logic [11:0] DEFAULT_BAUD_DIV = 12'd54
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [11:0]       baud_div,
  output logic              parity_en,
  output logic              two_stop,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic [7:0]        rx_data,
  output logic              rx_rd_en,
  input  logic              rx_full,
  input  logic              rx_empty,
  input  logic              rx_frame_error,
  input  logic              rx_overflow,
  output logic              irq
);

  bridge_state_t state;

  logic                frame_err_s;
  logic                rx_ovf_s;
  logic                tx_drop_s;
  logic [IRQ_EN_W-1:0] irq_en;

  // Register select: word index only, byte lanes ignored.
  logic [4:0] ofs;
  assign ofs = {req_addr[4:2], 2'b00};

  // Address bits above the map and the unused data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{req_addr, req_wdata[DATA_W-1:14]};

  logic accept;
  assign accept = req_valid & req_ready;

  logic mapped;
  assign mapped = (ofs <= IRQ_EN_OFS);

  // STATUS view: live UART flags plus sticky error bits.
  logic [STAT_W-1:0] status_vec;
  always_comb begin
    status_vec                 = '0;
    status_vec[STAT_TX_FULL]   = tx_full;
    status_vec[STAT_TX_EMPTY]  = tx_empty;
    status_vec[STAT_RX_FULL]   = rx_full;
    status_vec[STAT_RX_EMPTY]  = rx_empty;
    status_vec[STAT_FRAME_ERR] = frame_err_s;
    status_vec[STAT_RX_OVF]    = rx_ovf_s;
    status_vec[STAT_TX_DROP]   = tx_drop_s;
  end

  // Read data for the current request; captured into rsp_rdata on accept.
  logic [DATA_W-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (ofs)
      RXDATA_OFS: begin
        if (!rx_empty) begin
          rd_data[RXDATA_VALID] = 1'b1;
          rd_data[7:0]          = rx_data;
        end
      end
      STATUS_OFS: rd_data[STAT_W-1:0] = status_vec;
      CTRL_OFS: begin
        rd_data[CTRL_BAUD_LSB +: CTRL_BAUD_W] = baud_div;
        rd_data[CTRL_PARITY]                  = parity_en;
        rd_data[CTRL_TWO_STOP]                = two_stop;
      end
      IRQ_EN_OFS: rd_data[IRQ_EN_W-1:0] = irq_en;
      default:    rd_data = '0;
    endcase
  end

  // Write-1-to-clear strobes for the sticky bits.
  logic status_wr;
  logic clr_frame;
  logic clr_ovf;
  logic clr_drop;
  assign status_wr = accept & req_write & (ofs == STATUS_OFS);
  assign clr_frame = status_wr & req_wdata[STAT_FRAME_ERR];
  assign clr_ovf   = status_wr & req_wdata[STAT_RX_OVF];
  assign clr_drop  = status_wr & req_wdata[STAT_TX_DROP];

  logic drop_set;
  assign drop_set = accept & req_write & (ofs == TXDATA_OFS) & tx_full;

  logic irq_next;
  assign irq_next = (irq_en[IRQ_TX_READY] & ~tx_full)
                  | (irq_en[IRQ_RX_AVAIL] & ~rx_empty)
                  | (irq_en[IRQ_ERR] & (frame_err_s | rx_ovf_s | tx_drop_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      baud_div    <= DEFAULT_BAUD_DIV;
      parity_en   <= 1'b0;
      two_stop    <= 1'b0;
      tx_data     <= 8'd0;
      tx_wr_en    <= 1'b0;
      rx_rd_en    <= 1'b0;
      frame_err_s <= 1'b0;
      rx_ovf_s    <= 1'b0;
      tx_drop_s   <= 1'b0;
      irq_en      <= '0;
      irq         <= 1'b0;
    end else begin
      // UART strobes are single-cycle unless re-armed below.
      tx_wr_en <= 1'b0;
      rx_rd_en <= 1'b0;

      // A set in the same cycle as a clear wins because it is OR-ed last.
      frame_err_s <= (frame_err_s & ~clr_frame) | rx_frame_error;
      rx_ovf_s    <= (rx_ovf_s & ~clr_ovf) | rx_overflow;
      tx_drop_s   <= (tx_drop_s & ~clr_drop) | drop_set;

      irq <= irq_next;

      if (state == IDLE) begin
        if (accept) begin
          state     <= RESP;
          req_ready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= ~mapped;
          rsp_rdata <= req_write ? '0 : rd_data;

          if (req_write) begin
            case (ofs)
              TXDATA_OFS: begin
                if (!tx_full) begin
                  tx_wr_en <= 1'b1;
                  tx_data  <= req_wdata[7:0];
                end
              end
              CTRL_OFS: begin
                // A zero divider would stall the baud generator; clamp to 1.
                baud_div  <= (req_wdata[CTRL_BAUD_LSB +: CTRL_BAUD_W] == 12'd0)
                             ? 12'd1 : req_wdata[CTRL_BAUD_LSB +: CTRL_BAUD_W];
                parity_en <= req_wdata[CTRL_PARITY];
                two_stop  <= req_wdata[CTRL_TWO_STOP];
              end
              IRQ_EN_OFS: irq_en <= req_wdata[IRQ_EN_W-1:0];
              default: ;
            endcase
          end else if ((ofs == RXDATA_OFS) && !rx_empty) begin
            // Head byte was captured above; pop it on the following cycle.
            rx_rd_en <= 1'b1;
          end
        end
      end else begin
        if (rsp_ready) begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] baud_div;
  logic        parity_en;
  logic        two_stop;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_full = 1'b0;
  logic        tx_empty = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_rd_en;
  logic        rx_full = 1'b0;
  logic        rx_empty = 1'b1;
  logic        rx_frame_error = 1'b0;
  logic        rx_overflow = 1'b0;
  logic        irq;

  uart_reg_bridge #(
    .ADDR_W(5),
    .DATA_W(32),
    .DEFAULT_BAUD_DIV(12'd54)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .baud_div(baud_div),
    .parity_en(parity_en),
    .two_stop(two_stop),
    .tx_data(tx_data),
    .tx_wr_en(tx_wr_en),
    .tx_full(tx_full),
    .tx_empty(tx_empty),
    .rx_data(rx_data),
    .rx_rd_en(rx_rd_en),
    .rx_full(rx_full),
    .rx_empty(rx_empty),
    .rx_frame_error(rx_frame_error),
    .rx_overflow(rx_overflow),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboard of expected responses: {rsp_err, rsp_rdata}.
  logic [32:0] exp_q[$];

  // Strobe counters sampled on the inactive edge.
  int          tx_pulses = 0;
  int          rx_pulses = 0;
  logic [7:0]  last_tx = '0;
  always @(negedge clk) begin
    if (tx_wr_en) begin
      tx_pulses = tx_pulses + 1;
      last_tx   = tx_data;
    end
    if (rx_rd_en) rx_pulses = rx_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until it is accepted at a clock edge.
  task automatic req_issue(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    bit done = 0;
    exp_q.push_back({exp_err, exp_rdata});
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) done = 1;
      step();
    end
    req_valid = 1'b0;
    if (!done) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait for the response, compare with the scoreboard head, then consume it.
  task automatic rsp_wait(input string tag);
    bit          seen = 0;
    logic [32:0] e;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (rsp_valid) seen = 1;
      else step();
    end
    if (!seen) begin
      check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e[31:0]);
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
      if (rsp_ready) step();
    end
  endtask

  task automatic xact(input string tag, input logic wr, input logic [4:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    req_issue(wr, addr, wdata, exp_rdata, exp_err);
    rsp_wait(tag);
  endtask

  int tx0;
  int rx0;

  initial begin
    // 1. Reset state and defaults.
    step();
    step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_baud_div", {20'd0, baud_div}, 32'd54);
    check("rst_tx_wr_en", {31'd0, tx_wr_en}, 32'd0);
    reset_n = 1'b1;
    step();
    xact("ctrl_reset", 1'b0, 5'h0C, 32'd0, 32'h0000_0036, 1'b0);
    xact("status_idle", 1'b0, 5'h08, 32'd0, 32'h0000_000A, 1'b0);
    check("irq_idle", {31'd0, irq}, 32'd0);

    // 2. CTRL write with baud_div=0 is clamped to 1.
    req_issue(1'b1, 5'h0C, 32'h0000_3000, 32'd0, 1'b0);
    check("baud_div_next", {20'd0, baud_div}, 32'd1);
    check("parity_next", {31'd0, parity_en}, 32'd1);
    check("two_stop_next", {31'd0, two_stop}, 32'd1);
    rsp_wait("ctrl_wr");
    xact("ctrl_rb", 1'b0, 5'h0C, 32'd0, 32'h0000_3001, 1'b0);

    // 3. TX push, drop when full, W1C of the drop flag.
    tx0 = tx_pulses;
    req_issue(1'b1, 5'h00, 32'hFFFF_FFA5, 32'd0, 1'b0);
    check("tx_wr_en_next", {31'd0, tx_wr_en}, 32'd1);
    check("tx_data_next", {24'd0, tx_data}, 32'h0000_00A5);
    rsp_wait("tx_wr");
    check("tx_pulse_count", tx_pulses - tx0, 32'd1);
    check("tx_last_data", {24'd0, last_tx}, 32'h0000_00A5);
    tx_full  = 1'b1;
    tx_empty = 1'b0;
    xact("tx_wr_full", 1'b1, 5'h00, 32'h0000_005A, 32'd0, 1'b0);
    check("tx_no_pulse", tx_pulses - tx0, 32'd1);
    xact("status_drop", 1'b0, 5'h08, 32'd0, 32'h0000_0049, 1'b0);
    tx_full  = 1'b0;
    tx_empty = 1'b1;
    xact("status_w1c", 1'b1, 5'h08, 32'h0000_0040, 32'd0, 1'b0);
    xact("status_clr", 1'b0, 5'h08, 32'd0, 32'h0000_000A, 1'b0);

    // 4. RX pop with data present, then with the FIFO empty.
    rx0      = rx_pulses;
    rx_empty = 1'b0;
    rx_data  = 8'h3C;
    xact("rx_rd", 1'b0, 5'h04, 32'd0, 32'h8000_003C, 1'b0);
    rx_empty = 1'b1;
    rx_data  = 8'hEE;
    check("rx_pulse_count", rx_pulses - rx0, 32'd1);
    xact("rx_rd_empty", 1'b0, 5'h04, 32'd0, 32'd0, 1'b0);
    step();
    check("rx_no_pulse", rx_pulses - rx0, 32'd1);

    // 5. Error interrupt, sticky frame error, set beats W1C.
    xact("irq_en_wr", 1'b1, 5'h10, 32'h0000_0004, 32'd0, 1'b0);
    xact("irq_en_rb", 1'b0, 5'h10, 32'd0, 32'h0000_0004, 1'b0);
    check("irq_no_err", {31'd0, irq}, 32'd0);
    rx_frame_error = 1'b1;
    step();
    rx_frame_error = 1'b0;
    check("irq_latency", {31'd0, irq}, 32'd0);
    step();
    check("irq_set", {31'd0, irq}, 32'd1);
    xact("status_frame", 1'b0, 5'h08, 32'd0, 32'h0000_001A, 1'b0);
    rx_frame_error = 1'b1;
    req_issue(1'b1, 5'h08, 32'h0000_0010, 32'd0, 1'b0);
    rx_frame_error = 1'b0;
    rsp_wait("w1c_race");
    xact("status_race", 1'b0, 5'h08, 32'd0, 32'h0000_001A, 1'b0);
    xact("w1c_frame", 1'b1, 5'h08, 32'h0000_0010, 32'd0, 1'b0);
    xact("status_frame_clr", 1'b0, 5'h08, 32'd0, 32'h0000_000A, 1'b0);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // 6. Unmapped read, response backpressure, reset in RESP.
    rsp_ready = 1'b0;
    req_issue(1'b0, 5'h14, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    rsp_wait("unmapped");
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_baud", {20'd0, baud_div}, 32'd54);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    xact("ctrl_after_rst", 1'b0, 5'h0C, 32'd0, 32'h0000_0036, 1'b0);
    check("final_tx_pulses", tx_pulses - tx0, 32'd1);
    check("final_rx_pulses", rx_pulses - rx0, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Memory-mapped register front end that sits directly upstream of the UART top and drives its processor-side interface. It turns single-beat bus reads and writes into TX FIFO pushes, RX FIFO pops, configuration registers (baud_div, parity_en, two_stop), sticky error status and one combined interrupt line. It uses a valid/ready request channel and a valid/ready response channel, with one outstanding transaction.

Parameters:
ADDR_W, 5, byte-address width; bits [4:2] select the register, bits [1:0] are ignored.
DATA_W, 32, bus data width; fixed at 32.
DEFAULT_BAUD_DIV, 12'd54, reset value of CTRL.baud_div (16x oversampling).

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  bus request valid
req_ready  out  1  bridge can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  32  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes)
rsp_err  out  1  unmapped address
baud_div  out  12  to UART baud_div
parity_en  out  1  to UART parity_en
two_stop  out  1  to UART two_stop
tx_data  out  8  to UART tx_data
tx_wr_en  out  1  one-cycle TX push
tx_full, tx_empty  in  1 each  UART TX flags
rx_data  in  8  UART RX FIFO head (show-ahead, valid while rx_empty=0)
rx_rd_en  out  1  one-cycle RX pop
rx_full, rx_empty  in  1 each  UART RX flags
rx_frame_error, rx_overflow  in  1 each  UART error indicators
irq  out  1  combined interrupt

Behaviour:
- Register map:
  - 0x00 TXDATA (W): data is req_wdata[7:0].
  - 0x04 RXDATA (R): {valid[31], 23'b0, data[7:0]}.
  - 0x08 STATUS: R bits [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] frame_err_s, [5] rx_ovf_s, [6] tx_drop_s. Bits 4-6 are write-1-to-clear.
  - 0x0C CTRL (RW): [11:0] baud_div, [12] parity_en, [13] two_stop.
  - 0x10 IRQ_EN (RW): [0] tx_ready_en, [1] rx_avail_en, [2] err_en.
  - Any other offset: read returns 0, write is ignored, rsp_err=1.
- FSM states are IDLE and RESP.
  - IDLE: req_ready=1. On req_valid, the request is accepted and executed in that cycle; next state is RESP.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata/rsp_err stay stable until rsp_ready=1, then next state is IDLE.
  - Minimum cost is 2 cycles per transaction.
- TXDATA write when tx_full=0: tx_wr_en=1 for exactly the accept cycle and tx_data=req_wdata[7:0], registered so both are visible on the cycle after accept. When tx_full=1: no push, tx_drop_s is set.
- RXDATA read when rx_empty=0: rx_rd_en pulses for one cycle and rx_data is captured in the same cycle; the response is {1, 0, rx_data}. When rx_empty=1: no pop, response is 0.
- CTRL write of baud_div=0 is stored as 1. New values drive the UART from the next cycle.
- Sticky bits set whenever the corresponding input is high (frame_err_s from rx_frame_error, rx_ovf_s from rx_overflow). If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq = (tx_ready_en & ~tx_full) | (rx_avail_en & ~rx_empty) | (err_en & (frame_err_s|rx_ovf_s|tx_drop_s)). It is registered, so it has 1 cycle of latency.
- Reset values:
  - FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - baud_div=DEFAULT_BAUD_DIV, parity_en=0, two_stop=0.
  - tx_data=0, tx_wr_en=0, rx_rd_en=0.
  - sticky bits=0, IRQ_EN=0, irq=0.
- Reset asserted mid-transaction aborts it: the pending response is dropped, and a pulse already issued is not repeated.

Decomposition:
- Package uart_reg_pkg holds:
  - register offset localparams: TXDATA_OFS, RXDATA_OFS, STATUS_OFS, CTRL_OFS, IRQ_EN_OFS;
  - the STATUS/CTRL/IRQ_EN bit-index constants;
  - the FSM enum bridge_state_t {IDLE, RESP}.
- No sub-module. The sticky/irq logic stays inline.

Test Plan:
1. Reset release, read CTRL -> rdata=0x00000036. Read STATUS with UART idle -> bits 1 and 3 set (0x0000000A). irq=0.
2. Write CTRL=0x00003000 (baud_div=0) -> readback 0x00003001. baud_div=1, parity_en=1, two_stop=1 on the next cycle.
3. Write TXDATA=0xA5 with tx_full=0 -> one tx_wr_en pulse with tx_data=0xA5. Repeat with tx_full=1 -> no pulse, STATUS[6]=1. Write STATUS=0x40 -> bit 6 cleared.
4. rx_empty=0, rx_data=0x3C, read RXDATA -> rdata=0x8000003C and exactly one rx_rd_en pulse. Read with rx_empty=1 -> rdata=0, no pulse.
5. IRQ_EN=0x4, pulse rx_frame_error for 1 cycle -> STATUS[4]=1, irq=1 one cycle later. W1C of bit 4 in the same cycle as a new rx_frame_error -> bit stays 1.
6. Read offset 0x14 -> rdata=0, rsp_err=1. Hold rsp_ready=0 for 5 cycles -> rsp_valid held, req_ready=0 throughout. Assert reset_n=0 in RESP -> rsp_valid=0 immediately.
